clk_freq_meter: RTL
===================

Name: clk_freq_meter

Overview:
Measures the frequency of a slow, possibly asynchronous clock-like signal, such as the divided CPU clock, against the board clock clk. It counts rising edges of sig_in over a fixed gate window of GATE_CYCLES clk cycles and presents the count on a valid/ready result interface. It sits beside the clock divider and feeds debug/display logic, e.g. seven-segment or register readback, so the selected CPU clock rate can be confirmed on hardware.

Parameters:
GATE_CYCLES, 100000000, gate window length in clk cycles (1 s at 100 MHz); must be >= 2
GATE_W, 32, width of the gate counter; must hold GATE_CYCLES-1
CNT_W, 32, width of the edge counter and of meas_cnt

Ports:
clk  in  1  board clock
rst  in  1  reset
en  in  1  level enable; 1 = measure continuously
sig_in  in  1  signal under measurement, asynchronous to clk
meas_cnt  out  CNT_W  rising edges counted in the last completed window
meas_ovf  out  1  edge counter saturated during that window
meas_valid  out  1  result available
meas_ready  in  1  consumer accepts result
busy  out  1  high in ARM and GATE states

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk. All flops reset to 0, including synchronizer and edge-detect regs. State = IDLE.
- Output reset values: meas_cnt=0, meas_ovf=0, meas_valid=0, busy=0.
- Input path: 2-flop synchronizer on sig_in, then a registered copy. edge = sync_q & ~prev_q.
- Latency: an edge on sig_in reaches the counter 3 clk later.
- Input range: sig_in high and low phases must each be >= 1 clk period. A clk/2 square wave generated from clk is legal and measurable.
- The edge detector runs in every state. Edges are counted only while in GATE.
- FSM states: IDLE, ARM, GATE, HOLD.
  - IDLE: if en=1, go to ARM.
  - ARM (1 cycle): gate_cnt <= 0, edge_cnt <= 0, ovf <= 0. Go to GATE.
  - GATE: gate_cnt increments every cycle. If edge, edge_cnt increments, saturating at all-ones. If an edge arrives while edge_cnt is already all-ones, ovf <= 1.
    - On the cycle gate_cnt == GATE_CYCLES-1 (the window is exactly GATE_CYCLES cycles): meas_cnt <= edge_cnt plus the edge in this same cycle (saturating), meas_ovf <= ovf (including this cycle), meas_valid <= 1. Go to HOLD.
  - HOLD: meas_valid=1. meas_cnt and meas_ovf are stable until the transfer (meas_valid & meas_ready).
    - On transfer: meas_valid <= 0. Next state is ARM if en=1, else IDLE.
    - No new window starts until transfer; no result is ever overwritten or dropped.
- meas_cnt and meas_ovf keep their last value after transfer until the next result.
- en=0 during ARM or GATE: abort to IDLE next cycle. Partial count is discarded and meas_valid stays 0.
- en=0 during HOLD: the result is still held until transfer, then go to IDLE.
- rst mid-window or mid-HOLD: immediate return to reset values; pending result is lost.
- sig_in stuck at 0 or 1: the window completes with meas_cnt=0, meas_ovf=0.
- Expected count ≈ f_sig * GATE_CYCLES / f_clk, ±1 depending on phase.

Decomposition:
- Package clk_freq_meter_pkg: state enum (IDLE, ARM, GATE, HOLD) and the default GATE_CYCLES constant.
- One sub-module, sync_edge_det: 2-flop synchronizer plus rising-edge pulse, async reset. It is reusable for buttons and switches elsewhere in the design.

Test Plan:
1. GATE_CYCLES=1000, sig_in = clk/2 derived from clk (toggling flop), en=1, meas_ready=1 -> meas_valid pulses; meas_cnt in 499..500 (first window 499 or 500 depending on sync fill), 500 in every later window; meas_ovf=0.
2. GATE_CYCLES=1000, sig_in = asynchronous square wave, period 64.3 clk -> meas_cnt = 15 or 16 every window.
3. CNT_W=8, GATE_CYCLES=1000, sig_in = clk/2 -> meas_cnt=255, meas_ovf=1. Next window, with sig_in stuck at 0 -> meas_cnt=0, meas_ovf=0.
4. Backpressure: meas_ready=0 for 50 cycles after meas_valid rises -> meas_valid and meas_cnt stay constant, busy=0, no counting. On meas_ready=1 -> one-cycle transfer, then ARM and busy=1.
5. en dropped at gate cycle 400 -> IDLE next cycle, meas_valid never asserts. Re-assert en -> full new 1000-cycle window, correct count.
6. rst asserted mid-GATE, asynchronously between clk edges -> all outputs 0 immediately. After release with en=1 -> normal measurement resumes.

Source files
------------

// File: rtl/clk_freq_meter_pkg.sv
// clk_freq_meter_pkg
//   Shared types and defaults for the clock frequency meter.
//   - state_t             : measurement FSM states
//   - DEFAULT_GATE_CYCLES : gate window length for a 100 MHz board clock (1 s)
package clk_freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for en
    ST_ARM  = 2'd1,  // one cycle: clear window counters
    ST_GATE = 2'd2,  // counting edges over the gate window
    ST_HOLD = 2'd3   // result presented, waiting for meas_ready
  } state_t;

  localparam int unsigned DEFAULT_GATE_CYCLES = 32'd100_000_000;

endpackage : clk_freq_meter_pkg

// File: rtl/sync_edge_det.sv
// sync_edge_det
//   Brings an asynchronous level into the clk domain through a 2-flop
//   synchronizer and produces a one-cycle pulse on each rising edge of the
//   synchronized level. Usable for any slow async input (buttons, switches,
//   divided clocks).
//
// Ports:
//   clk      in   sampling clock
//   rst      in   asynchronous active-high reset, clears all three flops
//   async_in in   level asynchronous to clk
//   rise     out  1-cycle pulse: synchronized level went 0 -> 1
//
// Timing: a rising edge of async_in is captured by sync1 at the first clk
// edge, reaches sync2 at the second, and rise is high during the following
// cycle, so a consumer registering rise sees it at the third clk edge.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  logic sync1_d;
  logic sync2_d;
  logic prev_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule : sync_edge_det

// File: rtl/clk_freq_meter.sv
// clk_freq_meter
//   Counts rising edges of a slow, possibly asynchronous signal over a gate
//   window of GATE_CYCLES clk cycles and presents the count on a
//   valid/ready result interface. Runs back-to-back windows while en is
//   high; a new window only starts once the previous result is accepted.
//
// Ports:
//   clk        in   board clock
//   rst        in   asynchronous active-high reset
//   en         in   level enable, 1 = measure continuously
//   sig_in     in   signal under measurement (async to clk)
//   meas_cnt   out  edges counted in the last completed window (saturating)
//   meas_ovf   out  edge counter saturated during that window
//   meas_valid out  result available
//   meas_ready in   consumer accepts result
//   busy       out  high while arming or gating
//
// Parameters:
//   GATE_CYCLES  window length in clk cycles, >= 2
//   GATE_W       gate counter width, must hold GATE_CYCLES-1
//   CNT_W        edge counter / meas_cnt width
module clk_freq_meter
  import clk_freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEFAULT_GATE_CYCLES,
  parameter int unsigned GATE_W      = 32,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] meas_cnt,
  output logic             meas_ovf,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             busy
);

  // gate_cnt runs 0..GATE_LAST inside GATE, giving exactly GATE_CYCLES
  // counting cycles per window.
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  logic sig_edge;

  state_t             state_q,      state_d;
  logic [GATE_W-1:0]  gate_cnt_q,   gate_cnt_d;
  logic [CNT_W-1:0]   edge_cnt_q,   edge_cnt_d;
  logic               ovf_q,        ovf_d;
  logic [CNT_W-1:0]   meas_cnt_q,   meas_cnt_d;
  logic               meas_ovf_q,   meas_ovf_d;
  logic               meas_valid_q, meas_valid_d;

  logic edge_cnt_full;

  // Edge detector runs in every state so the synchronizer pipeline is
  // always warm when a window opens.
  sync_edge_det u_sync_edge_det (
    .clk      (clk),
    .rst      (rst),
    .async_in (sig_in),
    .rise     (sig_edge)
  );

  assign edge_cnt_full = &edge_cnt_q;

  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    ovf_d        = ovf_q;
    meas_cnt_d   = meas_cnt_q;
    meas_ovf_d   = meas_ovf_q;
    meas_valid_d = meas_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_ARM;
        end
      end

      ST_ARM: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else begin
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_d      = 1'b0;
          state_d    = ST_GATE;
        end
      end

      ST_GATE: begin
        if (!en) begin
          // Abort: the partial count is simply left behind and overwritten
          // by the next ARM.
          state_d = ST_IDLE;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
          if (sig_edge) begin
            if (edge_cnt_full) begin
              ovf_d = 1'b1;
            end else begin
              edge_cnt_d = edge_cnt_q + 1'b1;
            end
          end
          // Final window cycle: publish the next-state values so an edge
          // landing on this cycle is still included.
          if (gate_cnt_q == GATE_LAST) begin
            meas_cnt_d   = edge_cnt_d;
            meas_ovf_d   = ovf_d;
            meas_valid_d = 1'b1;
            state_d      = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        // The result is never dropped: en only decides where to go after
        // the consumer has taken it.
        if (meas_valid_q && meas_ready) begin
          meas_valid_d = 1'b0;
          state_d      = en ? ST_ARM : ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      meas_cnt_q   <= '0;
      meas_ovf_q   <= 1'b0;
      meas_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      ovf_q        <= ovf_d;
      meas_cnt_q   <= meas_cnt_d;
      meas_ovf_q   <= meas_ovf_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  assign meas_cnt   = meas_cnt_q;
  assign meas_ovf   = meas_ovf_q;
  assign meas_valid = meas_valid_q;
  assign busy       = (state_q == ST_ARM) || (state_q == ST_GATE);

endmodule : clk_freq_meter
